// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signal bundle shared by alu_arbiter and its users.
// The slave modport is the arbiter's view; the master modport is the requester/ALU view.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_srca;
  logic [DATA_WIDTH-1:0] req0_srcb;
  logic [2:0]            req0_ctrl;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_srca;
  logic [DATA_WIDTH-1:0] req1_srcb;
  logic [2:0]            req1_ctrl;
  logic [DATA_WIDTH-1:0] alu_SrcA;
  logic [DATA_WIDTH-1:0] alu_SrcB;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;

  modport slave (
    input  req0_valid, req0_srca, req0_srcb, req0_ctrl,
    input  req1_valid, req1_srca, req1_srcb, req1_ctrl,
    output req0_ready, req1_ready,
    output alu_SrcA, alu_SrcB, alu_ctrl,
    input  alu_result, alu_zero,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_srca, req0_srcb, req0_ctrl,
    output req1_valid, req1_srca, req1_srcb, req1_ctrl,
    input  req0_ready, req1_ready,
    input  alu_SrcA, alu_SrcB, alu_ctrl,
    output alu_result, alu_zero,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Optional perf counters (grant_cnt0/1, conflict_cnt) are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
  output logic [CNT_WIDTH-1:0] conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic                  last_grant_reg;
  logic                  tag_reg;
  logic [DATA_WIDTH-1:0] alu_srca_reg;
  logic [DATA_WIDTH-1:0] alu_srcb_reg;
  logic [2:0]            alu_ctrl_reg;
  logic [DATA_WIDTH-1:0] rsp_result_reg;
  logic                  rsp_zero_reg;
  logic [1:0]            rsp_valid_reg;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_ready;
  logic                  grant_idx;
  logic                  accept;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] sel_srca;
  logic [DATA_WIDTH-1:0] sel_srcb;
  logic [2:0]            sel_ctrl;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    grant_idx = 1'b0;
    if (&req_valid) grant_idx = ~last_grant_reg;
    else            grant_idx = ~req_valid[0];
  end

  assign sel_srca = grant_idx ? bus.req1_srca : bus.req0_srca;
  assign sel_srcb = grant_idx ? bus.req1_srcb : bus.req0_srcb;
  assign sel_ctrl = grant_idx ? bus.req1_ctrl : bus.req0_ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_next           = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready[tag_reg]) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      tag_reg        <= 1'b0;
      alu_srca_reg   <= '0;
      alu_srcb_reg   <= '0;
      alu_ctrl_reg   <= '0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_valid_reg  <= 2'b00;
    end else begin
      if (accept) begin
        alu_srca_reg   <= sel_srca;
        alu_srcb_reg   <= sel_srcb;
        alu_ctrl_reg   <= sel_ctrl;
        tag_reg        <= grant_idx;
        last_grant_reg <= grant_idx;
      end
      // The ALU has had a full cycle on the registered operands by the end of EXEC.
      if (state_reg == EXEC) begin
        rsp_result_reg         <= bus.alu_result;
        rsp_zero_reg           <= bus.alu_zero;
        rsp_valid_reg[tag_reg] <= 1'b1;
      end
      if (rsp_done) rsp_valid_reg <= 2'b00;
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.alu_SrcA   = alu_srca_reg;
  assign bus.alu_SrcB   = alu_srcb_reg;
  assign bus.alu_ctrl   = alu_ctrl_reg;
  assign bus.rsp0_valid = rsp_valid_reg[0];
  assign bus.rsp1_valid = rsp_valid_reg[1];
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_zero   = rsp_zero_reg;

`ifdef ALU_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] grant_cnt_reg [2];
  logic [CNT_WIDTH-1:0] conflict_cnt_reg;

  // All counters stick at all-ones instead of wrapping.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant_cnt
      always_ff @(posedge clk) begin
        if (!rst_n)
          grant_cnt_reg[gi] <= '0;
        else if (accept && (grant_idx == 1'(gi)) && !(&grant_cnt_reg[gi]))
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)
      conflict_cnt_reg <= '0;
    else if ((state_reg == IDLE) && (&req_valid) && !(&conflict_cnt_reg))
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
  end

  assign grant_cnt0   = grant_cnt_reg[0];
  assign grant_cnt1   = grant_cnt_reg[1];
  assign conflict_cnt = conflict_cnt_reg;
`else
  wire [CNT_WIDTH-1:0] unused_cnt_width = '0;
`endif

endmodule
